// File: rtl/sram22_generic.sv
// Single-port synchronous SRAM model for the sram22 family: parametric size,
// lane write mask, optional output register and a post-reset array clear.
module sram22_generic #(
  parameter int DATA_WIDTH     = 22,
  parameter int ADDR_WIDTH     = 6,
  parameter int WMASK_WIDTH    = 1,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
`ifdef USE_POWER_PINS
  inout  wire                    vdd,
  inout  wire                    vss,
`endif
  input  logic                   clk,
  input  logic                   rstb,
  input  logic                   ce,
  input  logic                   we,
  input  logic [WMASK_WIDTH-1:0] wmask,
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic [DATA_WIDTH-1:0]  din,
  output logic [DATA_WIDTH-1:0]  dout,
  output logic                   dout_valid,
  output logic                   busy
);

  // state | meaning
  // IDLE  | accepting reads and writes
  // CLEAR | zeroing one word per cycle, accesses ignored
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_CLEAR = 1'b1;

  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam int LANE      = DATA_WIDTH / WMASK_WIDTH;

  generate
    if ((DATA_WIDTH % WMASK_WIDTH) != 0) begin : g_bad_mask
      $error("sram22_generic: WMASK_WIDTH must divide DATA_WIDTH");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
  logic                  state;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  rd;
  logic                  wr;
  logic [DATA_WIDTH-1:0] rdata;

  assign rd    = (state == ST_IDLE) && ce && !we;
  assign wr    = (state == ST_IDLE) && ce && we;
  assign rdata = mem[addr];
  assign busy  = (state == ST_CLEAR);

  // Array has no reset; reset edges must leave contents alone.
  always_ff @(posedge clk) begin
    if (rstb) begin
      if (state == ST_CLEAR) begin
        mem[clr_addr] <= '0;
      end else if (wr) begin
        for (int i = 0; i < WMASK_WIDTH; i++) begin
          if (wmask[i]) mem[addr][i*LANE +: LANE] <= din[i*LANE +: LANE];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      clr_addr <= '0;
    end else if (state == ST_CLEAR) begin
      clr_addr <= clr_addr + 1'b1;
      if (&clr_addr) state <= ST_IDLE;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] stage;
      logic                  stage_valid;

      always_ff @(posedge clk) begin
        if (!rstb) begin
          stage       <= '0;
          stage_valid <= 1'b0;
          dout        <= '0;
          dout_valid  <= 1'b0;
        end else begin
          stage_valid <= rd;
          if (rd) stage <= rdata;
          dout_valid  <= stage_valid;
          if (stage_valid) dout <= stage;
        end
      end
    end else begin : g_no_out_reg
      always_ff @(posedge clk) begin
        if (!rstb) begin
          dout       <= '0;
          dout_valid <= 1'b0;
        end else begin
          dout_valid <= rd;
          if (rd) dout <= rdata;
        end
      end
    end
  endgenerate

endmodule

// File: doc/sram22_generic.md
# sram22_generic

Parametrised behavioural model of a single-port synchronous SRAM macro in the sram22 family. It generalises the fixed-size model in four ways: width and depth are parameters, writes take a lane write mask, an optional output pipeline register can be enabled, and a post-reset clear sequencer can zero the array. It sits wherever a generated sram22 macro is instantiated and serves as the simulation and synthesis-stub view.

## Interface
Parameters:
- DATA_WIDTH, 22, word width in bits.
- ADDR_WIDTH, 6, address width; RAM_DEPTH = 1 << ADDR_WIDTH.
- WMASK_WIDTH, 1, number of write lanes.
  - Must divide DATA_WIDTH; LANE = DATA_WIDTH / WMASK_WIDTH.
  - A non-divisor is an elaboration error.
- OUT_REG, 0, 1 adds one output pipeline stage.
- CLEAR_ON_RESET, 1, 1 zeroes the whole array after reset.

Ports:
- vdd, vss  inout  1  power and ground; present only under `USE_POWER_PINS`.
- clk  input  1  clock. All logic acts on the rising edge.
- rstb  input  1  reset, synchronous, active-low.
- ce  input  1  chip enable.
- we  input  1  write enable: 1 = write, 0 = read.
- wmask  input  WMASK_WIDTH  lane write enable; bit i covers din[i*LANE +: LANE].
- addr  input  ADDR_WIDTH  word address.
- din  input  DATA_WIDTH  write data.
- dout  output  DATA_WIDTH  read data, registered.
- dout_valid  output  1  one-cycle pulse marking new read data on dout.
- busy  output  1  clear sequence in progress; accesses are ignored while high.

## Operation
- Reset: every edge with rstb=0 sets:
  - dout=0, dout_valid=0, pipeline stage=0, clr_addr=0.
  - state=CLEAR and busy=1 if CLEAR_ON_RESET; otherwise state=IDLE and busy=0.
  - Array contents are not touched by reset itself.
- State CLEAR:
  - Each edge writes mem[clr_addr] = 0 and increments clr_addr.
  - On the edge that writes address RAM_DEPTH-1, state becomes IDLE and busy becomes 0.
  - ce, we, wmask, addr and din are ignored.
- State IDLE:
  - ce=1, we=1: for each lane i with wmask[i]=1, write mem[addr] lane i from din lane i. Unmasked lanes keep their value. dout holds.
  - ce=1, we=0: read mem[addr].
  - ce=0: no access; dout holds.
- Read-after-write to the same address on the next cycle returns the newly written data.
- dout changes only when read data arrives. Writes, idle cycles and the CLEAR state never alter dout.
- Reset mid-CLEAR restarts the clear from address 0.
- Reset mid-read discards the read: no dout_valid pulse, and dout=0.
- With CLEAR_ON_RESET=0, array contents survive reset. They are X at simulation start.

## Timing
- Clear duration: exactly RAM_DEPTH cycles.
  - The first edge with rstb=1 clears address 0.
  - busy is low after edge RAM_DEPTH-1.
  - The first access is accepted on edge RAM_DEPTH (counting the first rstb=1 edge as edge 0).
- OUT_REG=0: a read sampled at edge N puts data on dout after edge N; dout_valid=1 for the cycle after edge N.
- OUT_REG=1:
  - Data goes into the stage register at edge N and reaches dout at edge N+1.
  - dout_valid is delayed by the same amount.
  - Back-to-back reads give one result per cycle.
- Write latency: one edge; the data is visible to a read sampled on the next edge.
- dout_valid is never high for two cycles from a single read. Consecutive reads give consecutive pulses.

## Test plan
- Clear (CLEAR_ON_RESET=1, ADDR_WIDTH=6):
  - Stimulus: rstb low for 2 cycles, then high, with ce=1, we=1, din=0x3FFFFF held throughout.
  - Required: busy high for exactly 64 cycles. Reading addresses 0, 31 and 63 afterwards returns 0 with dout_valid pulses.
- Masked write (WMASK_WIDTH=2, LANE=11):
  - Stimulus: write 0x3FFFFF to addr 5 with wmask=2'b11, then 0x000000 with wmask=2'b01, then read addr 5.
  - Required: dout=0x3FF800.
- Output pipeline (OUT_REG=1):
  - Stimulus: write 0x155555 to addr 1 and 0x2AAAAA to addr 2, then read addr 1 then addr 2 on consecutive edges N and N+1.
  - Required: dout=0x155555 after edge N+1 and 0x2AAAAA after edge N+2, with dout_valid high in both cycles.
- Hold behaviour:
  - Stimulus: after reading 0x155555, issue a write to addr 9, then 3 cycles of ce=0.
  - Required: dout stays 0x155555 and dout_valid stays 0.
- Reset mid-clear:
  - Stimulus: drop rstb after 20 clear cycles, then release it.
  - Required: busy stays high for a full 64 further cycles.
  - Stimulus: reset during an outstanding OUT_REG=1 read.
  - Required: no dout_valid pulse, and dout=0.
- Retention (CLEAR_ON_RESET=0):
  - Stimulus: write 0x0ABCDE to addr 63, pulse rstb, then read addr 63.
  - Required: busy is never high, and the read returns 0x0ABCDE.
